ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Sits directly downstream of the coherence controller and directly upstream of the single-ported RAM.
- Merges the coherence controller's data-side RAM request with the two per-CPU icache fetch requests.
- Grants exactly one requester at a time, holds the grant until the RAM reports completion, and returns wait/load to the winner.
- Data requests have priority; an anti-starvation counter guarantees instruction fetch progress.

Parameters:
- CPUS, 2, number of icache requesters (block is specified for 2).
- DATA_BURST_MAX, 4, consecutive completed data accesses allowed while any iREN is pending before one instruction access is forced.

Ports:
- CLK in 1: clock, rising edge.
- RST in 1: reset, asynchronous, active-high.
- iREN in [CPUS]: icache fetch request per CPU.
- iaddr in [CPUS] x32: fetch address per CPU.
- iwait out [CPUS]: low only in the completion cycle of that CPU's fetch.
- iload out [CPUS] x32: fetch data; ramload to the owner, 0 otherwise.
- d_ramREN in 1: data read request from the coherence controller.
- d_ramWEN in 1: data write request from the coherence controller.
- d_ramaddr in 32: data address.
- d_ramstore in 32: data write value.
- d_wait out 1: wait_in to the coherence controller; low only in the data completion cycle.
- d_ramload out 32: ramload when data owns the grant, 0 otherwise.
- ramREN out 1: RAM read enable.
- ramWEN out 1: RAM write enable.
- ramaddr out 32: RAM address.
- ramstore out 32: RAM write data.
- ramload in 32: RAM read data.
- ramstate in 2: ramstate_t {FREE, BUSY, ACCESS, ERROR}.

Behaviour:
- Reset (RST high, async):
  - state=IDLE, burst_cnt=0, last_icpu=1, so CPU0 wins the first instruction tie.
  - Outputs while reset is asserted: iwait=2'b11, d_wait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=d_ramload=0.
- States: IDLE, DGRANT, IGRANT0, IGRANT1.
- IDLE (zero-bubble): the winner is chosen combinationally and drives the RAM in the same cycle.
  - Priority 1: an instruction request is pending and burst_cnt==DATA_BURST_MAX. Winner is the round-robin icache, i.e. the pending CPU that is not last_icpu, else the only pending CPU.
  - Priority 2: data, if d_ramREN|d_ramWEN.
  - Priority 3: round-robin icache.
  - No request: RAM outputs idle, state stays IDLE.
  - If the winner's access completes in that same cycle, the FSM stays IDLE; otherwise it moves to the owner state.
- Owner states: the RAM is driven from the owner's live inputs each cycle. Non-owners see wait=1 and load=0.
  - Data owner: ramWEN=d_ramWEN; ramREN=d_ramREN & ~d_ramWEN (write wins if both asserted); ramaddr=d_ramaddr; ramstore=d_ramstore.
  - Icache owner: ramREN=1, ramWEN=0, ramaddr=iaddr[owner], ramstore=0.
- Completion: ramstate==ACCESS while a request is driven.
  - The owner's wait goes low and its load = ramload in that cycle.
  - Next state is IDLE; re-arbitration happens the next cycle.
- ERROR: treated as retry. Grant is held, the request is re-driven, and wait stays high.
- Request withdrawn while owned (owner's enable low): RAM enables go low that cycle, and the next state is IDLE with no completion.
- burst_cnt:
  - On data completion: +1 if any iREN is asserted, saturating at DATA_BURST_MAX; cleared to 0 if no iREN is asserted.
  - On instruction completion: cleared to 0.
- last_icpu: updates to the completing CPU on each instruction completion.
- Simultaneous data and instruction requests with burst_cnt<MAX: data wins; icache waits.
- Back-to-back coherence pairs (LOAD_0/LOAD_1, WRITE_BACK_0/1) are not atomic; an icache may interleave only through the starvation rule.

Decomposition:
- From cpu_types_pkg: word_t, ramstate_t.
- Add to cpu_types_pkg: arb_state_t {IDLE, DGRANT, IGRANT0, IGRANT1}.
- Optional sub-module rr_picker (2-way round-robin select from req[1:0] and last).
- FSM and burst counter stay in ram_arbiter.

Test Plan:
- Reset check: RST high with all requests high -> iwait=11, d_wait=1, ramREN=ramWEN=0. RST low with idle inputs -> state stays IDLE.
- Single fetch: iREN[0]=1, iaddr[0]=0x40, RAM gives ACCESS on the 2nd cycle with ramload=0xDEADBEEF -> ramaddr=0x40, ramREN=1 both cycles; iwait[0]=0 and iload[0]=0xDEADBEEF in cycle 2 only.
- Priority plus round-robin: iREN=11 and d_ramWEN=1 (addr 0x80, data 0x1234) together -> data is written first. Then CPU0 then CPU1 are served, and the next tie goes to CPU0.
- Starvation: d_ramREN held high with iREN[1]=1, 1-cycle RAM -> exactly 4 data completions, then 1 fetch for CPU1 (iwait[1]=0), then data resumes with burst_cnt=0.
- Hazards:
  - d_ramREN=d_ramWEN=1 -> only ramWEN=1.
  - ramstate=ERROR for 2 cycles then ACCESS -> d_wait stays high until the ACCESS cycle.
- Mid-operation events:
  - Owner drops iREN before ACCESS -> ramREN=0 that cycle, and the FSM returns to IDLE.
  - RST asserted mid-grant -> outputs go to reset values immediately, no RAM enable.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM word, RAM handshake state
// and the RAM arbiter FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    DGRANT,
    IGRANT0,
    IGRANT1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Two-way round-robin select: on a tie the side
// that was not served last wins.
module rr_picker (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       sel
);

  always_comb begin
    valid = |req;
    sel   = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: data side first, two icaches
// round-robin, with a burst limit so fetches cannot starve.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS           = 2,
  parameter int DATA_BURST_MAX = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [CPUS-1:0] iREN,
  input  word_t           iaddr [CPUS],
  output logic [CPUS-1:0] iwait,
  output word_t           iload [CPUS],
  input  logic            d_ramREN,
  input  logic            d_ramWEN,
  input  word_t           d_ramaddr,
  input  word_t           d_ramstore,
  output logic            d_wait,
  output word_t           d_ramload,
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  input  word_t           ramload,
  input  ramstate_t       ramstate
);

  localparam int BW = $clog2(DATA_BURST_MAX + 1);
  localparam logic [BW-1:0] BMAX = BW'(DATA_BURST_MAX);

  arb_state_t    state, next_state;
  logic [BW-1:0] burst_cnt;
  logic          last_icpu;

  logic rr_valid, rr_sel;
  logic own_d, own_i, own_cpu;
  logic active, done;

  rr_picker u_rr (
    .req   (iREN[1:0]),
    .last  (last_icpu),
    .valid (rr_valid),
    .sel   (rr_sel)
  );

  always_comb begin
    own_d      = 1'b0;
    own_i      = 1'b0;
    own_cpu    = 1'b0;
    next_state = IDLE;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = '1;
    d_wait     = 1'b1;
    d_ramload  = '0;
    for (int i = 0; i < CPUS; i++) iload[i] = '0;

    unique case (state)
      IDLE: begin
        if (rr_valid && burst_cnt == BMAX) begin
          own_i   = 1'b1;
          own_cpu = rr_sel;
        end else if (d_ramREN || d_ramWEN) begin
          own_d = 1'b1;
        end else if (rr_valid) begin
          own_i   = 1'b1;
          own_cpu = rr_sel;
        end
      end
      DGRANT:  own_d = 1'b1;
      IGRANT0: own_i = 1'b1;
      IGRANT1: begin
        own_i   = 1'b1;
        own_cpu = 1'b1;
      end
    endcase

    if (own_d) begin
      ramWEN   = d_ramWEN;
      ramREN   = d_ramREN & ~d_ramWEN;
      ramaddr  = d_ramaddr;
      ramstore = d_ramstore;
    end else if (own_i) begin
      ramREN  = iREN[own_cpu];
      ramaddr = iaddr[own_cpu];
    end

    active = ramREN | ramWEN;
    done   = active && ramstate == ACCESS;

    if (own_d) begin
      d_wait    = ~done;
      d_ramload = ramload;
    end else if (own_i) begin
      iwait[own_cpu] = ~done;
      iload[own_cpu] = ramload;
    end

    // ERROR and BUSY keep the grant; a dropped request releases it
    if (active && !done) begin
      if (own_d)        next_state = DGRANT;
      else if (own_cpu) next_state = IGRANT1;
      else              next_state = IGRANT0;
    end

    if (RST) begin
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = '0;
      ramstore  = '0;
      iwait     = '1;
      d_wait    = 1'b1;
      d_ramload = '0;
      for (int i = 0; i < CPUS; i++) iload[i] = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_icpu <= 1'b1;
    end else begin
      state <= next_state;
      if (done && own_d) begin
        if (!(|iREN))             burst_cnt <= '0;
        else if (burst_cnt != BMAX) burst_cnt <= burst_cnt + 1'b1;
      end
      if (done && own_i) begin
        burst_cnt <= '0;
        last_icpu <= own_cpu;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter against
// a grant-holder reference model.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      RST;
  logic [1:0] iREN;
  word_t     iaddr [2];
  logic [1:0] iwait;
  word_t     iload [2];
  logic      d_ramREN, d_ramWEN;
  word_t     d_ramaddr, d_ramstore;
  logic      d_wait;
  word_t     d_ramload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  int total = 0;
  int bad = 0;
  int h, bc, last;
  logic       last_dw, last_ren, last_wen;
  logic [1:0] last_iw;
  word_t      last_addr;

  always #5 CLK = ~CLK;

  ram_arbiter #(.CPUS(2), .DATA_BURST_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .d_ramREN(d_ramREN), .d_ramWEN(d_ramWEN),
    .d_ramaddr(d_ramaddr), .d_ramstore(d_ramstore),
    .d_wait(d_wait), .d_ramload(d_ramload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    h    = -1;
    bc   = 0;
    last = 1;
  endtask

  task automatic chk_reset_outs;
    chk("rst_iwait", {30'd0, iwait}, 32'd3);
    chk("rst_dwait", {31'd0, d_wait}, 32'd1);
    chk("rst_ren", {31'd0, ramREN}, 32'd0);
    chk("rst_wen", {31'd0, ramWEN}, 32'd0);
    chk("rst_addr", ramaddr, 32'd0);
    chk("rst_store", ramstore, 32'd0);
    chk("rst_iload0", iload[0], 32'd0);
    chk("rst_iload1", iload[1], 32'd0);
    chk("rst_dload", d_ramload, 32'd0);
  endtask

  // One cycle: drive at posedge+1, check mid-cycle, advance model.
  task automatic step(input logic [1:0] ir, input word_t a0, a1,
                      input logic dr, dw, input word_t da, ds,
                      input int rs, input word_t rl);
    int win, pick;
    logic ren, wen, done, e_dw;
    logic [1:0] e_iw;
    word_t ea, es, e_il0, e_il1, e_dl;
    iREN = ir; iaddr[0] = a0; iaddr[1] = a1;
    d_ramREN = dr; d_ramWEN = dw; d_ramaddr = da; d_ramstore = ds;
    ramstate = ramstate_t'(rs[1:0]); ramload = rl;
    #4;
    pick = (ir == 2'b11) ? 1 - last : (ir[0] ? 0 : 1);
    if (h >= 0)                   win = h;
    else if (ir != 0 && bc == 4)  win = 1 + pick;
    else if (dr || dw)            win = 0;
    else if (ir != 0)             win = 1 + pick;
    else                          win = -1;
    ren = 0; wen = 0; ea = 0; es = 0;
    if (win == 0) begin
      wen = dw; ren = dr && !dw; ea = da; es = ds;
    end else if (win > 0) begin
      ren = ir[win-1];
      ea  = (win == 1) ? a0 : a1;
    end
    done = (ren || wen) && rs == 2;
    e_iw = 2'b11; e_dw = 1; e_il0 = 0; e_il1 = 0; e_dl = 0;
    if (win == 0) begin e_dw = !done; e_dl = rl; end
    if (win == 1) begin e_iw[0] = !done; e_il0 = rl; end
    if (win == 2) begin e_iw[1] = !done; e_il1 = rl; end
    chk("ren", {31'd0, ramREN}, {31'd0, ren});
    chk("wen", {31'd0, ramWEN}, {31'd0, wen});
    chk("addr", ramaddr, ea);
    chk("store", ramstore, es);
    chk("iwait", {30'd0, iwait}, {30'd0, e_iw});
    chk("dwait", {31'd0, d_wait}, {31'd0, e_dw});
    chk("iload0", iload[0], e_il0);
    chk("iload1", iload[1], e_il1);
    chk("dload", d_ramload, e_dl);
    last_dw = d_wait; last_iw = iwait;
    last_ren = ramREN; last_wen = ramWEN; last_addr = ramaddr;
    if (done && win == 0) bc = (ir != 0) ? ((bc < 4) ? bc + 1 : 4) : 0;
    if (done && win > 0) begin bc = 0; last = win - 1; end
    h = (win < 0 || done || !(ren || wen)) ? -1 : win;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    #1;
    chk_reset_outs();
    model_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    iREN = 2'b11; iaddr[0] = 32'h4; iaddr[1] = 32'h8;
    d_ramREN = 1; d_ramWEN = 1; d_ramaddr = 32'h10; d_ramstore = 32'h5;
    ramstate = ACCESS; ramload = 32'hAAAA5555;
    model_reset();
    @(posedge CLK); #1;
    chk_reset_outs();
    RST = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 2, 32'h2);

    // single fetch, completes on the second cycle
    step(2'b01, 32'h40, 0, 0, 0, 0, 0, 1, 32'h0);
    chk("fetch_c1_ren", {31'd0, last_ren}, 32'd1);
    chk("fetch_c1_iw", {30'd0, last_iw}, 32'd3);
    step(2'b01, 32'h40, 0, 0, 0, 0, 0, 2, 32'hDEADBEEF);
    chk("fetch_c2_addr", last_addr, 32'h40);
    chk("fetch_c2_iw", {30'd0, last_iw}, 32'd2);

    // priority then round robin
    do_reset();
    step(2'b11, 32'hA0, 32'hB0, 0, 1, 32'h80, 32'h1234, 2, 32'h0);
    chk("prio_wen", {31'd0, last_wen}, 32'd1);
    chk("prio_addr", last_addr, 32'h80);
    step(2'b11, 32'hA0, 32'hB0, 0, 0, 0, 0, 2, 32'h11);
    chk("rr_cpu0", last_addr, 32'hA0);
    step(2'b11, 32'hA0, 32'hB0, 0, 0, 0, 0, 2, 32'h22);
    chk("rr_cpu1", last_addr, 32'hB0);
    step(2'b11, 32'hA0, 32'hB0, 0, 0, 0, 0, 2, 32'h33);
    chk("rr_cpu0_again", last_addr, 32'hA0);

    // starvation limit
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step(2'b10, 0, 32'hC0, 1, 0, 32'h100 + k, 0, 2, $urandom);
      chk("starve_dw", {31'd0, last_dw}, (k == 4) ? 32'd1 : 32'd0);
      chk("starve_iw1", {31'd0, last_iw[1]}, (k == 4) ? 32'd0 : 32'd1);
    end

    // read+write together, then ERROR retries
    do_reset();
    step(0, 0, 0, 1, 1, 32'h200, 32'h77, 2, 32'h0);
    chk("rw_ren", {31'd0, last_ren}, 32'd0);
    chk("rw_wen", {31'd0, last_wen}, 32'd1);
    step(0, 0, 0, 1, 0, 32'h204, 0, 3, 32'h1);
    chk("err1_dw", {31'd0, last_dw}, 32'd1);
    step(0, 0, 0, 1, 0, 32'h204, 0, 3, 32'h2);
    chk("err2_dw", {31'd0, last_dw}, 32'd1);
    step(0, 0, 0, 1, 0, 32'h204, 0, 2, 32'h3);
    chk("err_done_dw", {31'd0, last_dw}, 32'd0);

    // owner withdraws fetch
    step(2'b01, 32'h300, 0, 0, 0, 0, 0, 1, 32'h0);
    step(2'b00, 32'h300, 0, 0, 0, 0, 0, 1, 32'h0);
    chk("withdraw_ren", {31'd0, last_ren}, 32'd0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // reset mid-grant
    step(2'b01, 32'h400, 0, 0, 0, 0, 0, 1, 32'h0);
    do_reset();
    step(2'b01, 32'h404, 0, 0, 0, 0, 0, 2, 32'h9);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      int rs;
      logic [1:0] ir;
      logic dr, dw;
      r  = $urandom_range(0, 9);
      rs = (r < 5) ? 2 : (r < 7) ? 1 : (r < 9) ? 3 : 0;
      ir = 2'($urandom);
      dr = ($urandom_range(0, 3) != 0);
      dw = ($urandom_range(0, 3) == 0);
      step(ir, $urandom, $urandom, dr, dw, $urandom, $urandom, rs, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
